// File: rtl/load_scoreboard_if.sv
// load_scoreboard_if
//   Groups the ID-stage decode signals, the data-memory response and the
//   stall controls exchanged with the load scoreboard.
//   master : pipeline side (drives ID/response fields, reads stall controls)
//   slave  : scoreboard side
//   Signals:
//     id_valid, id_rs1, id_rs2, id_use_rs1, id_use_rs2, id_rd, id_MemRead,
//     flush                    - ID stage decode / squash
//     resp_valid, resp_rd      - data memory load response
//     PCwrite, IF_IDwrite,
//     control_sel              - stall controls
//     pending, outstanding,
//     resp_err                 - scoreboard status
interface load_scoreboard_if #(
    parameter int MAX_LOADS = 2,
    parameter int CNT_W     = $clog2(MAX_LOADS + 1)
);
    logic             id_valid;
    logic [4:0]       id_rs1;
    logic [4:0]       id_rs2;
    logic             id_use_rs1;
    logic             id_use_rs2;
    logic [4:0]       id_rd;
    logic             id_MemRead;
    logic             flush;
    logic             resp_valid;
    logic [4:0]       resp_rd;
    logic             PCwrite;
    logic             IF_IDwrite;
    logic             control_sel;
    logic [31:0]      pending;
    logic [CNT_W-1:0] outstanding;
    logic             resp_err;

    modport master (
        output id_valid, id_rs1, id_rs2, id_use_rs1, id_use_rs2, id_rd,
               id_MemRead, flush, resp_valid, resp_rd,
        input  PCwrite, IF_IDwrite, control_sel, pending, outstanding, resp_err
    );

    modport slave (
        input  id_valid, id_rs1, id_rs2, id_use_rs1, id_use_rs2, id_rd,
               id_MemRead, flush, resp_valid, resp_rd,
        output PCwrite, IF_IDwrite, control_sel, pending, outstanding, resp_err
    );
endinterface

// File: rtl/load_scoreboard.sv
// load_scoreboard
//   Tracks destination registers of loads in flight to a variable-latency
//   data memory and stalls ID when a decoded instruction reads or would
//   overwrite one of them, or when too many loads are already in flight.
//   Ports:
//     clk    - system clock, rising edge
//     rst_n  - asynchronous active-low reset
//     sb     - load_scoreboard_if.slave (ID decode, memory response,
//              stall controls, pending bitmap, outstanding count, resp_err)
module load_scoreboard #(
    parameter int MAX_LOADS = 2,
    parameter int CNT_W     = $clog2(MAX_LOADS + 1)
) (
    input  logic               clk,
    input  logic               rst_n,
    load_scoreboard_if.slave   sb
);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_LOADS);

    logic [31:1]      pend;
    logic [CNT_W-1:0] cnt;
    logic             err;

    // Bit 0 is hard zero so x0 never looks pending when indexed.
    logic [31:0] pend_full;
    assign pend_full = {pend, 1'b0};

    logic haz_rs1, haz_rs2, haz_waw, haz_cap, stall;
    logic issue_set, retire_ok;
    logic [31:0] pend_nx;

    always_comb begin
        haz_rs1 = sb.id_use_rs1 && (sb.id_rs1 != 5'd0) && pend_full[sb.id_rs1];
        haz_rs2 = sb.id_use_rs2 && (sb.id_rs2 != 5'd0) && pend_full[sb.id_rs2];
        haz_waw = sb.id_MemRead && (sb.id_rd != 5'd0) && pend_full[sb.id_rd];
        haz_cap = sb.id_MemRead && (cnt == CNT_MAX);
        stall   = sb.id_valid && !sb.flush &&
                  (haz_rs1 || haz_rs2 || haz_waw || haz_cap);

        // Loads to x0 pass through untracked.
        issue_set = sb.id_valid && !sb.flush && !stall && sb.id_MemRead &&
                    (sb.id_rd != 5'd0);
        // A pending bit implies cnt > 0, so this also guards underflow.
        retire_ok = sb.resp_valid && (sb.resp_rd != 5'd0) && pend_full[sb.resp_rd];

        // WAW stall keeps issue and retire off the same register, so the
        // order of set/clear here never matters.
        pend_nx = pend_full;
        if (issue_set) pend_nx[sb.id_rd]   = 1'b1;
        if (retire_ok) pend_nx[sb.resp_rd] = 1'b0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pend <= '0;
            cnt  <= '0;
            err  <= 1'b0;
        end else begin
            pend <= pend_nx[31:1];
            case ({issue_set, retire_ok})
                2'b10:   cnt <= cnt + CNT_ONE;
                2'b01:   cnt <= cnt - CNT_ONE;
                default: cnt <= cnt;
            endcase
            if (sb.resp_valid && !retire_ok) err <= 1'b1;
        end
    end

    assign sb.PCwrite     = !stall;
    assign sb.IF_IDwrite  = !stall;
    assign sb.control_sel = stall;
    assign sb.pending     = pend_full;
    assign sb.outstanding = cnt;
    assign sb.resp_err    = err;
endmodule

// File: tb/tb_load_scoreboard.sv
module tb_load_scoreboard;
    localparam int MAX_LOADS = 2;
    localparam int CNT_W     = $clog2(MAX_LOADS + 1);

    logic clk;
    logic rst_n;
    int   n_tests;
    int   n_fail;

    load_scoreboard_if #(.MAX_LOADS(MAX_LOADS), .CNT_W(CNT_W)) sb_if ();

    load_scoreboard #(.MAX_LOADS(MAX_LOADS), .CNT_W(CNT_W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .sb    (sb_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        sb_if.id_valid   = 1'b0;
        sb_if.id_rs1     = 5'd0;
        sb_if.id_rs2     = 5'd0;
        sb_if.id_use_rs1 = 1'b0;
        sb_if.id_use_rs2 = 1'b0;
        sb_if.id_rd      = 5'd0;
        sb_if.id_MemRead = 1'b0;
        sb_if.flush      = 1'b0;
        sb_if.resp_valid = 1'b0;
        sb_if.resp_rd    = 5'd0;
    endtask

    task automatic id_load(input logic [4:0] rd);
        sb_if.id_valid   = 1'b1;
        sb_if.id_MemRead = 1'b1;
        sb_if.id_rd      = rd;
        sb_if.id_use_rs1 = 1'b0;
        sb_if.id_use_rs2 = 1'b0;
    endtask

    task automatic id_use1(input logic [4:0] rs);
        sb_if.id_valid   = 1'b1;
        sb_if.id_MemRead = 1'b0;
        sb_if.id_rd      = 5'd0;
        sb_if.id_rs1     = rs;
        sb_if.id_use_rs1 = 1'b1;
        sb_if.id_use_rs2 = 1'b0;
    endtask

    task automatic resp(input logic [4:0] rd);
        sb_if.resp_valid = 1'b1;
        sb_if.resp_rd    = rd;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        #2;
        rst_n = 1'b1;
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        n_tests = 0;
        n_fail  = 0;
        idle();
        rst_n = 1'b0;
        #12;
        check("rst_pcwrite", 32'(sb_if.PCwrite), 32'd1);
        check("rst_ifid", 32'(sb_if.IF_IDwrite), 32'd1);
        check("rst_csel", 32'(sb_if.control_sel), 32'd0);
        check("rst_pending", sb_if.pending, 32'h0);
        check("rst_outst", 32'(sb_if.outstanding), 32'd0);
        check("rst_err", 32'(sb_if.resp_err), 32'd0);
        rst_n = 1'b1;
        tick();

        // Load-use
        id_load(5'd5); #1;
        check("lu_issue_nostall", 32'(sb_if.control_sel), 32'd0);
        tick();
        id_use1(5'd5); #1;
        check("lu_csel", 32'(sb_if.control_sel), 32'd1);
        check("lu_pcwrite", 32'(sb_if.PCwrite), 32'd0);
        check("lu_ifid", 32'(sb_if.IF_IDwrite), 32'd0);
        check("lu_pending", sb_if.pending, 32'h20);
        check("lu_outst", 32'(sb_if.outstanding), 32'd1);
        tick();
        check("lu_cyc2_stall", 32'(sb_if.control_sel), 32'd1);
        tick();
        resp(5'd5); #1;
        check("lu_resp_no_bypass", 32'(sb_if.control_sel), 32'd1);
        tick();
        sb_if.resp_valid = 1'b0; #1;
        check("lu_release", 32'(sb_if.control_sel), 32'd0);
        check("lu_release_pc", 32'(sb_if.PCwrite), 32'd1);
        check("lu_pend_clr", sb_if.pending, 32'h0);
        check("lu_outst_clr", 32'(sb_if.outstanding), 32'd0);
        check("lu_err", 32'(sb_if.resp_err), 32'd0);
        idle(); tick();

        // x0 handling
        id_load(5'd0); #1;
        check("x0_load_nostall", 32'(sb_if.control_sel), 32'd0);
        tick();
        id_use1(5'd0); #1;
        check("x0_use_nostall", 32'(sb_if.control_sel), 32'd0);
        check("x0_outst", 32'(sb_if.outstanding), 32'd0);
        check("x0_pending", sb_if.pending, 32'h0);
        idle(); resp(5'd0); tick();
        idle(); #1;
        check("x0_resp_err", 32'(sb_if.resp_err), 32'd1);
        check("x0_err_outst", 32'(sb_if.outstanding), 32'd0);
        do_reset();
        check("x0_err_cleared", 32'(sb_if.resp_err), 32'd0);
        tick();

        // Capacity
        id_load(5'd1); tick();
        id_load(5'd2); #1;
        check("cap_second_ok", 32'(sb_if.control_sel), 32'd0);
        tick();
        id_load(5'd3); #1;
        check("cap_full_stall", 32'(sb_if.control_sel), 32'd1);
        check("cap_outst2", 32'(sb_if.outstanding), 32'd2);
        check("cap_pend", sb_if.pending, 32'h6);
        tick();
        resp(5'd1); #1;
        check("cap_still_stall", 32'(sb_if.control_sel), 32'd1);
        tick();
        sb_if.resp_valid = 1'b0; #1;
        check("cap_released", 32'(sb_if.control_sel), 32'd0);
        check("cap_outst1", 32'(sb_if.outstanding), 32'd1);
        tick();
        idle(); #1;
        check("cap_outst_back2", 32'(sb_if.outstanding), 32'd2);
        check("cap_pend_23", sb_if.pending, 32'hC);
        resp(5'd2); tick();
        resp(5'd3); tick();
        idle(); #1;
        check("cap_drain", 32'(sb_if.outstanding), 32'd0);
        check("cap_no_err", 32'(sb_if.resp_err), 32'd0);

        // Simultaneous issue and retire
        id_load(5'd4); tick();
        id_load(5'd6); resp(5'd4); #1;
        check("sim_nostall", 32'(sb_if.control_sel), 32'd0);
        tick();
        idle(); #1;
        check("sim_pending", sb_if.pending, 32'h40);
        check("sim_outst", 32'(sb_if.outstanding), 32'd1);
        resp(5'd6); tick();
        idle(); #1;
        check("sim_drain", 32'(sb_if.outstanding), 32'd0);

        // WAW, flush and rs2 hazard
        id_load(5'd7); tick();
        id_load(5'd7); #1;
        check("waw_stall", 32'(sb_if.control_sel), 32'd1);
        sb_if.flush = 1'b1; #1;
        check("flush_nostall", 32'(sb_if.control_sel), 32'd0);
        check("flush_pcwrite", 32'(sb_if.PCwrite), 32'd1);
        tick();
        idle(); #1;
        check("flush_no_issue", 32'(sb_if.outstanding), 32'd1);
        check("flush_pend", sb_if.pending, 32'h80);
        sb_if.id_valid = 1'b1; sb_if.id_rs2 = 5'd7; sb_if.id_use_rs2 = 1'b1; #1;
        check("rs2_stall", 32'(sb_if.control_sel), 32'd1);
        sb_if.id_use_rs2 = 1'b0; #1;
        check("rs2_unused_nostall", 32'(sb_if.control_sel), 32'd0);
        idle(); id_use1(5'd7); sb_if.id_valid = 1'b0; #1;
        check("invalid_nostall", 32'(sb_if.control_sel), 32'd0);

        // Reset mid-flight
        idle(); id_load(5'd8); tick();
        idle(); resp(5'd9); tick();
        idle(); #1;
        check("rf_outst2", 32'(sb_if.outstanding), 32'd2);
        check("rf_err_set", 32'(sb_if.resp_err), 32'd1);
        id_use1(5'd7); #1;
        check("rf_pre_stall", 32'(sb_if.control_sel), 32'd1);
        rst_n = 1'b0; #1;
        check("rf_pending", sb_if.pending, 32'h0);
        check("rf_outst", 32'(sb_if.outstanding), 32'd0);
        check("rf_err", 32'(sb_if.resp_err), 32'd0);
        check("rf_pcwrite", 32'(sb_if.PCwrite), 32'd1);
        check("rf_csel", 32'(sb_if.control_sel), 32'd0);
        #2;
        rst_n = 1'b1;
        idle(); tick();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/load_scoreboard.md
# load_scoreboard

Tracks destination registers of loads issued into the pipeline but not yet returned by a variable-latency data memory, and stalls the ID stage when a decoded instruction would read or overwrite such a register. It is the writer side of the load-hazard interface: it records pending load destinations at issue and clears them on memory response. It drives the same stall controls the pipeline already consumes (PCwrite, IF_IDwrite, control_sel). It sits between the ID stage decode outputs and the data-memory response path.

## Interface
- MAX_LOADS, 2: maximum outstanding loads (1..31).
- CNT_W, $clog2(MAX_LOADS+1): width of the outstanding-load counter.

- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- id_valid  input  1  ID stage holds a valid instruction.
- id_rs1, id_rs2  input  5  source register indices.
- id_use_rs1, id_use_rs2  input  1  instruction actually reads that source.
- id_rd  input  5  destination register index.
- id_MemRead  input  1  ID instruction is a load.
- flush  input  1  ID instruction is squashed this cycle (branch taken).
- resp_valid  input  1  data memory returns load data this cycle.
- resp_rd  input  5  destination register of the returning load.
- PCwrite  output  1  0 = hold PC.
- IF_IDwrite  output  1  0 = hold IF/ID register.
- control_sel  output  1  1 = inject bubble into ID/EX.
- pending  output  32  pending-load bitmap; bit 0 always 0.
- outstanding  output  CNT_W  number of loads in flight.
- resp_err  output  1  sticky: response for a register not pending.

## Operation
- State: pend[31:1], cnt (CNT_W), err. All clear on reset.
- stall (combinational, registered state only, no same-cycle response bypass) = id_valid && !flush && any of:
  - id_use_rs1 && id_rs1!=0 && pend[id_rs1];
  - id_use_rs2 && id_rs2!=0 && pend[id_rs2];
  - id_MemRead && id_rd!=0 && pend[id_rd] (WAW: at most one outstanding load per register);
  - id_MemRead && cnt==MAX_LOADS.
- Outputs: PCwrite = !stall, IF_IDwrite = !stall, control_sel = stall.
- issue = id_valid && !flush && !stall && id_MemRead. If id_rd!=0, set pend[id_rd] and increment cnt. A load to x0 is not tracked.
- retire = resp_valid. If resp_rd!=0 and pend[resp_rd]: clear the bit and decrement cnt. Otherwise (x0, not pending, or cnt==0): no state change, set err.
- Same cycle, issue and retire to different registers: both apply; cnt unchanged.
- Same cycle, issue and retire to the same register: cannot occur through a legal issue, because the WAW stall blocks it. Only a retire occurs.
- cnt never wraps. The capacity stall prevents overflow, and the err path prevents underflow.
- pending output = {pend, 1'b0}; outstanding = cnt; resp_err = err.

## Timing
- Stall outputs are combinational from the current-cycle ID inputs and registered state.
- A load issued in cycle N sets its pending bit at edge N+1. A dependent instruction in ID during cycle N+1 is stalled, which gives the classic 1-cycle load-use bubble as a minimum.
- A response in cycle M clears the bit at edge M+1. The stalled consumer proceeds in cycle M+1, so response-to-release latency is 1 cycle.
- Reset asserted mid-operation clears pend, cnt and err immediately (asynchronous). Outputs then read PCwrite=1, IF_IDwrite=1, control_sel=0, pending=0, outstanding=0, resp_err=0 regardless of ID inputs.
- flush forces stall=0 and suppresses issue in the same cycle.

## Test plan
- Load-use: cycle 0 issue load rd=5. Cycle 1, ID reads rs1=5 -> control_sel=1, PCwrite=0. resp_valid rd=5 in cycle 3 -> stall released in cycle 4, pending=0.
- x0 handling: load rd=0, then consumer rs1=0 -> no stall, outstanding=0. Response rd=0 -> resp_err=1.
- Capacity: MAX_LOADS=2, issue loads rd=1 and rd=2, third load rd=3 -> stalled while outstanding=2. Response rd=1 -> load rd=3 issues the following cycle, outstanding returns to 2.
- Simultaneous: pend[4] set, issue load rd=6 while resp_valid rd=4 -> next cycle pending=32'h40, outstanding=1.
- WAW and flush: pend[7] set, ID load rd=7 -> stall. Same case with flush=1 -> stall=0 and no issue.
- Reset mid-flight: two loads pending, pulse rst_n low -> pending=0, outstanding=0, resp_err=0, PCwrite=1 asynchronously.
